// File: rtl/pulse_train_gen_if.sv
// Control/status bundle between a pulse-train requester and pulse_train_gen.
// Handshake: start is accepted on a rising clk edge only while busy=0; stop is honoured only while busy=1.
// done pulses for exactly one cycle with busy=0, and a new start may be accepted in that same cycle.
interface pulse_train_gen_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] count_in;
    logic             stop;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;

    modport master (
        output start,
        output count_in,
        output stop,
        input  pulse_out,
        input  busy,
        input  done,
        input  sent
    );

    modport slave (
        input  start,
        input  count_in,
        input  stop,
        output pulse_out,
        output busy,
        output done,
        output sent
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Emits a train of fixed-width, synchronizer-safe pulses on pulse_out, with graceful stop and a done strobe.
// Optional feature macro PULSE_TRAIN_CONT_EN: a start with count_in=0 runs a continuous train until stop.
module pulse_train_gen #(
    parameter int CNT_W       = 8,
    parameter int HIGH_CYCLES = 3,
    parameter int LOW_CYCLES  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    pulse_train_gen_if.slave         bus,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [7:0] HIGH_LAST = 8'(HIGH_CYCLES - 1);
    localparam logic [7:0] LOW_LAST  = 8'(LOW_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       phase_q, phase_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stop_pend_q, stop_pend_d;
`ifdef PULSE_TRAIN_CONT_EN
    logic             cont_q, cont_d;
`endif

    logic stop_eff;
    logic more_pulses;

    // A stop arriving on the very edge that closes a LOW phase must still end the train.
    assign stop_eff = stop_pend_q | bus.stop;

`ifdef PULSE_TRAIN_CONT_EN
    assign more_pulses = cont_q | (remaining_q != '0);
`else
    assign more_pulses = (remaining_q != '0);
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        sent_d      = sent_q;
        pulse_d     = pulse_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
`ifdef PULSE_TRAIN_CONT_EN
        cont_d      = cont_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sent_d = '0;
`ifdef PULSE_TRAIN_CONT_EN
                    // Zero count means run forever; remaining is unused in that mode.
                    state_d     = HIGH;
                    phase_d     = '0;
                    pulse_d     = 1'b1;
                    busy_d      = 1'b1;
                    sent_d      = CNT_W'(1);
                    stop_pend_d = 1'b0;
                    cont_d      = (bus.count_in == '0);
                    remaining_d = (bus.count_in == '0) ? '0 : bus.count_in - CNT_W'(1);
`else
                    if (bus.count_in != '0) begin
                        state_d     = HIGH;
                        phase_d     = '0;
                        pulse_d     = 1'b1;
                        busy_d      = 1'b1;
                        sent_d      = CNT_W'(1);
                        stop_pend_d = 1'b0;
                        remaining_d = bus.count_in - CNT_W'(1);
                    end else begin
                        done_d = 1'b1;
                    end
`endif
                end
            end

            HIGH: begin
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                if (phase_q == HIGH_LAST) begin
                    state_d = LOW;
                    phase_d = '0;
                    pulse_d = 1'b0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            LOW: begin
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                if (phase_q == LOW_LAST) begin
                    phase_d = '0;
                    if (more_pulses && !stop_eff) begin
                        state_d = HIGH;
                        pulse_d = 1'b1;
                        sent_d  = sent_q + CNT_W'(1);
`ifdef PULSE_TRAIN_CONT_EN
                        if (!cont_q) begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end
`else
                        remaining_d = remaining_q - CNT_W'(1);
`endif
                    end else begin
                        state_d     = IDLE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                        remaining_d = '0;
`ifdef PULSE_TRAIN_CONT_EN
                        cont_d      = 1'b0;
`endif
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            default: begin
                state_d     = IDLE;
                phase_d     = '0;
                pulse_d     = 1'b0;
                busy_d      = 1'b0;
                stop_pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            remaining_q <= '0;
            sent_q      <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
`ifdef PULSE_TRAIN_CONT_EN
            cont_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            sent_q      <= sent_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
`ifdef PULSE_TRAIN_CONT_EN
            cont_q      <= cont_d;
`endif
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sent      = sent_q;
    assign dbg_state     = state_q;

endmodule
